nec_ir_transmitter: RTL
=======================

# nec_ir_transmitter

NEC infrared transmitter: the encoder counterpart of the snake game's `irReceiver`. It serialises an 8-bit address and an 8-bit command into a standard NEC frame, or into an NEC repeat code, and drives an IR LED output with an optional 38 kHz carrier. It is used for receiver loopback testing on the board and for driving the game from a second FPGA acting as a remote.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: input clock frequency in Hz.
- `CARRIER_HZ`, default 38_000: carrier frequency.
- `MODULATE`, default 1: 1 = marks carry the square-wave carrier; 0 = marks are a constant 1 (baseband, for direct wiring to the receiver input).

Ports:
- `CLOCK_50`, input, 1: clock. One clock domain only.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: request a full frame; sampled only in IDLE.
- `repeat_req`, input, 1: request a repeat code; sampled only in IDLE.
- `addr`, input, 8: address, captured when `start` is accepted.
- `cmd`, input, 8: command, captured when `start` is accepted.
- `busy`, output, 1: high while a frame or repeat is in progress.
- `done`, output, 1: one-cycle pulse when the final stop mark ends.
- `ir_out`, output, 1: LED drive, where 1 = emitter on.

## Operation
- Timebase: tick = 562.5 µs, which is `TICK_CYCLES = CLK_FREQ*9/16000` (28125 at 50 MHz). Compute this product in 64-bit; truncate by integer division.
- Frame word = {~cmd, cmd, ~addr, addr}. Bit 0 is sent first (LSB first, address first).
- Full frame sequence:
  - leader mark, 16 ticks;
  - leader space, 8 ticks;
  - 32 bits, each a 1-tick mark followed by a space of 1 tick (bit 0) or 3 ticks (bit 1);
  - stop mark, 1 tick.
- Repeat code sequence: mark 16 ticks, space 4 ticks, stop mark 1 tick.
- State machine:
  - IDLE → LEAD_MARK on `start` or `repeat_req`.
  - LEAD_MARK → LEAD_SPACE (frame) or RPT_SPACE (repeat).
  - LEAD_SPACE → BIT_MARK.
  - BIT_MARK → BIT_SPACE.
  - BIT_SPACE → BIT_MARK while the bit index is below 31, else STOP_MARK.
  - RPT_SPACE → STOP_MARK.
  - STOP_MARK → IDLE, pulsing `done`.
- Mark output:
  - `MODULATE=1`: 50% square wave with half-period `CLK_FREQ/(2*CARRIER_HZ)` cycles (657 at 50 MHz). The carrier phase counter restarts at each mark start, so every mark begins high.
  - `MODULATE=0`: constant 1.
- Space output and IDLE output: `ir_out = 0`.
- `start` and `repeat_req` high in the same IDLE cycle: `start` wins and the repeat request is dropped.
- Requests while `busy` are ignored (no queueing). `addr` and `cmd` changes after acceptance have no effect.
- Frame length is data-independent: 121 ticks. Each byte and its complement contribute 8 ones and 8 zeros, so the 32 bits take 96 ticks.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `ir_out=0`, all counters 0.
- Reset asserted mid-frame: outputs go to their reset values immediately and asynchronously. No partial frame resumes.
- Acceptance latency: a request sampled at edge N gives `busy=1` and the first mark level on `ir_out` from edge N+1. `ir_out` is registered.
- Segment lengths are exactly ticks × `TICK_CYCLES` clock cycles. There is no slip between segments: the tick counter reloads on the same edge the state advances.
- Total duration:
  - full frame: 121 × 28125 = 3,403,125 cycles;
  - repeat code: 21 × 28125 = 590,625 cycles.
- `done` is high for exactly one cycle, coincident with the first cycle of `busy=0`. A new request can be accepted in that same cycle.
- Inter-frame spacing (NEC 108 ms period) is the caller's responsibility.

## Structure
- Package `nec_pkg` holds:
  - state enum `nec_state_t`;
  - tick-count constants `LEAD_MARK_TICKS=16`, `LEAD_SPACE_TICKS=8`, `RPT_SPACE_TICKS=4`, `BIT_MARK_TICKS=1`, `ZERO_SPACE_TICKS=1`, `ONE_SPACE_TICKS=3`, `STOP_TICKS=1`;
  - function `nec_frame_word(addr, cmd)`.
- Sub-module `ir_carrier_gen` (inputs: clock, reset, `enable`, `restart`; output: `carrier`) handles carrier division and phase restart. The tick counter and FSM stay in the top.
- The package is shared with `irReceiver` for the tick constants.

## Test plan
Benches may override `CLK_FREQ=16000` and `CARRIER_HZ=1000`, giving `TICK_CYCLES=9` and a carrier half-period of 8.
- Reset check: after reset, `ir_out`, `busy` and `done` are all 0. Pulse `reset_n` low 3×TICK into a frame → `ir_out=0` and `busy=0` within the same cycle, then the block stays idle.
- Frame content: `start` with `addr=0x00`, `cmd=0x45` (`MODULATE=0`) → mark/space tick sequence 16/8, then bits LSB-first of 0xBA45FF00, then stop 1. Total 121×9 = 1089 busy cycles, then a single `done` pulse.
- Repeat code: `repeat_req` (`MODULATE=0`) → `ir_out` high 144 cycles, low 36, high 9, then `done`; busy 189 cycles.
- Request priority and ignoring: `start` and `repeat_req` in the same IDLE cycle → full frame (1089 cycles). `start` pulsed mid-frame with `addr=0xFF` → no effect on the frame or the following IDLE.
- Carrier (`MODULATE=1`) → during each mark `ir_out` toggles every 8 cycles, starting high on the mark's first cycle. `ir_out` stays constant 0 during spaces.
- Back-to-back: `start` asserted in the `done` cycle → the next frame's `busy` rises on the following edge with no idle gap. Loopback into `irReceiver` decodes the word 0xBA45FF00.

Source files
------------

// File: rtl/nec_pkg.sv
// Shared NEC IR definitions: FSM states, segment tick counts and frame packing.
package nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_RPT_SPACE  = 3'd5,
    ST_STOP_MARK  = 3'd6
  } nec_state_t;

  localparam int unsigned LEAD_MARK_TICKS  = 16;
  localparam int unsigned LEAD_SPACE_TICKS = 8;
  localparam int unsigned RPT_SPACE_TICKS  = 4;
  localparam int unsigned BIT_MARK_TICKS   = 1;
  localparam int unsigned ZERO_SPACE_TICKS = 1;
  localparam int unsigned ONE_SPACE_TICKS  = 3;
  localparam int unsigned STOP_TICKS       = 1;

  localparam int unsigned FRAME_BITS = 32;

  // Over-the-air word, transmitted LSB first: address, ~address, command, ~command.
  function automatic logic [31:0] nec_frame_word(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  // States during which the emitter is driven (carrier or constant high).
  function automatic logic nec_is_mark(input nec_state_t s);
    return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave carrier whose phase restarts high at the first cycle of every mark.
module ir_carrier_gen #(
  parameter int unsigned HALF_PERIOD = 657
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic restart_i,
  output logic carrier_o
);

  localparam int unsigned HP   = (HALF_PERIOD == 0) ? 1 : HALF_PERIOD;
  localparam int unsigned PH_W = (HP > 1) ? $clog2(HP) : 1;

  logic [PH_W-1:0] phase_q;
  logic            carrier_q;

  // enable_i/restart_i describe the coming cycle, so carrier_q lines up with the mark it gates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q   <= '0;
      carrier_q <= 1'b0;
    end else if (restart_i) begin
      phase_q   <= '0;
      carrier_q <= 1'b1;
    end else if (enable_i) begin
      if (phase_q == PH_W'(HP - 1)) begin
        phase_q   <= '0;
        carrier_q <= ~carrier_q;
      end else begin
        phase_q <= phase_q + PH_W'(1);
      end
    end else begin
      phase_q   <= '0;
      carrier_q <= 1'b0;
    end
  end

  assign carrier_o = carrier_q;

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR encoder: serialises address/command frames or repeat codes onto an IR LED drive.
module nec_ir_transmitter
  import nec_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned CARRIER_HZ = 38_000,
  parameter int unsigned MODULATE   = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       start,
  input  logic       repeat_req,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_out
);

  localparam int unsigned TICK_RAW    = 32'((64'(CLK_FREQ) * 64'd9) / 64'd16000);
  localparam int unsigned TICK_CYCLES = (TICK_RAW == 0) ? 1 : TICK_RAW;
  localparam int unsigned HALF_PERIOD = CLK_FREQ / (2 * CARRIER_HZ);
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned IDX_W       = 5;

  // Cycle count for a segment, minus one, so the counter ends at zero on its last cycle.
  function automatic logic [CNT_W-1:0] seg_load(input int unsigned ticks);
    return CNT_W'(ticks * TICK_CYCLES - 1);
  endfunction

  nec_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [31:0]      frame_q, frame_d;
  logic             rpt_q, rpt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mark_q, mark_d;
  logic             seg_end_c;
  logic             restart_c;
  logic             carrier;

  assign seg_end_c = (cnt_q == '0);

  // Next-state: accept requests in IDLE, count down each segment, advance on its last cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    rpt_d     = rpt_q;
    done_d    = 1'b0;

    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d   = ST_LEAD_MARK;
        cnt_d     = seg_load(LEAD_MARK_TICKS);
        frame_d   = nec_frame_word(addr, cmd);
        rpt_d     = 1'b0;
        bit_idx_d = '0;
      end else if (repeat_req) begin
        state_d   = ST_LEAD_MARK;
        cnt_d     = seg_load(LEAD_MARK_TICKS);
        rpt_d     = 1'b1;
        bit_idx_d = '0;
      end
    end else if (!seg_end_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      case (state_q)
        ST_LEAD_MARK: begin
          state_d = rpt_q ? ST_RPT_SPACE : ST_LEAD_SPACE;
          cnt_d   = rpt_q ? seg_load(RPT_SPACE_TICKS) : seg_load(LEAD_SPACE_TICKS);
        end
        ST_LEAD_SPACE: begin
          state_d = ST_BIT_MARK;
          cnt_d   = seg_load(BIT_MARK_TICKS);
        end
        ST_BIT_MARK: begin
          state_d = ST_BIT_SPACE;
          cnt_d   = frame_q[bit_idx_q] ? seg_load(ONE_SPACE_TICKS) : seg_load(ZERO_SPACE_TICKS);
        end
        ST_BIT_SPACE: begin
          if (bit_idx_q < IDX_W'(FRAME_BITS - 1)) begin
            state_d   = ST_BIT_MARK;
            cnt_d     = seg_load(BIT_MARK_TICKS);
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end else begin
            state_d = ST_STOP_MARK;
            cnt_d   = seg_load(STOP_TICKS);
          end
        end
        ST_RPT_SPACE: begin
          state_d = ST_STOP_MARK;
          cnt_d   = seg_load(STOP_TICKS);
        end
        ST_STOP_MARK: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    mark_d = nec_is_mark(state_d);
  end

  // A mark always follows a space or IDLE, so a rising mark_d marks a fresh mark.
  assign restart_c = mark_d & ~mark_q;

  // State, counters and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      rpt_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mark_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      rpt_q     <= rpt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mark_q    <= mark_d;
    end
  end

  ir_carrier_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_carrier (
    .clk_i    (CLOCK_50),
    .rst_ni   (reset_n),
    .enable_i (mark_d),
    .restart_i(restart_c),
    .carrier_o(carrier)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign ir_out = (MODULATE != 0) ? carrier : mark_q;

endmodule
